// File: rtl/clk_gen_pkg.sv
// Shared constants, divisor type and divisor clamping for the multi-channel clock generator.
package clk_gen_pkg;

  localparam int unsigned CNT_W_DEFAULT   = 28;
  localparam int unsigned DEF_DIV_DEFAULT = 25000000;

  typedef logic [CNT_W_DEFAULT-1:0] div_t;

  // A divisor of zero has no meaningful period, so it is treated as one.
  function automatic div_t clamp_div(input div_t k);
    return (k == '0) ? div_t'(1) : k;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/shadow divisor, tick pulse and 50% square output.
module clk_div_channel
  import clk_gen_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned DEF_DIV = DEF_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sync,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_data,
  output logic             tick,
  output logic             clk_out,
  output logic             pending
);

  localparam logic [CNT_W-1:0] RST_DIV = (DEF_DIV == 0) ? CNT_W'(1) : CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_active_q, div_active_d;
  logic [CNT_W-1:0] div_shadow_q, div_shadow_d;
  logic             pending_q, pending_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;
  logic [CNT_W-1:0] ld_k;
  logic [CNT_W-1:0] sync_div;
  logic             rollover;

  if (CNT_W == CNT_W_DEFAULT) begin : g_pkg_clamp
    assign ld_k = clamp_div(ld_data);
  end else begin : g_local_clamp
    assign ld_k = (ld_data == '0) ? CNT_W'(1) : ld_data;
  end

  assign rollover = (cnt_q == div_active_q - CNT_W'(1));
  assign sync_div = ld ? ld_k : div_shadow_q;

  always_comb begin
    cnt_d        = cnt_q;
    div_active_d = div_active_q;
    div_shadow_d = div_shadow_q;
    pending_d    = pending_q;
    tick_d       = 1'b0;
    clk_out_d    = clk_out_q;

    if (sync) begin
      cnt_d        = '0;
      clk_out_d    = 1'b0;
      div_shadow_d = sync_div;
      div_active_d = sync_div;
      pending_d    = 1'b0;
    end else begin
      if (!en) begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end else if (rollover) begin
        cnt_d     = '0;
        tick_d    = 1'b1;
        clk_out_d = ~clk_out_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      // Apply the old shadow first; a write on this same edge stays pending for the next period.
      if (pending_q && (!en || rollover)) begin
        div_active_d = div_shadow_q;
        pending_d    = 1'b0;
      end
      if (ld) begin
        div_shadow_d = ld_k;
        pending_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      div_active_q <= RST_DIV;
      div_shadow_q <= RST_DIV;
      pending_q    <= 1'b0;
      tick_q       <= 1'b0;
      clk_out_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      div_active_q <= div_active_d;
      div_shadow_q <= div_shadow_d;
      pending_q    <= pending_d;
      tick_q       <= tick_d;
      clk_out_q    <= clk_out_d;
    end
  end

  assign tick    = tick_q;
  assign clk_out = clk_out_q;
  assign pending = pending_q;

endmodule

// File: rtl/multi_clock_gen.sv
// N-channel programmable clock generator: write decode, range error flag and channel array.
module multi_clock_gen
  import clk_gen_pkg::*;
#(
  parameter int unsigned N_CH    = 3,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned DEF_DIV = DEF_DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_CH-1:0]       ch_en,
  input  logic                  sync,
  input  logic                  wr_en,
  input  logic [$clog2(N_CH):0] wr_ch,
  input  logic [CNT_W-1:0]      wr_data,
  output logic                  wr_err,
  output logic [N_CH-1:0]       pending,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       clk_out
);

  localparam int unsigned CH_W = $clog2(N_CH) + 1;

  logic [N_CH-1:0] ld;
  logic            wr_err_q, wr_err_d;

  always_comb begin
    ld = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      ld[i] = wr_en && (wr_ch == CH_W'(i));
    end
    wr_err_d = wr_en && (wr_ch >= CH_W'(N_CH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
    end
  end

  assign wr_err = wr_err_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (ch_en[g]),
      .sync    (sync),
      .ld      (ld[g]),
      .ld_data (wr_data),
      .tick    (tick[g]),
      .clk_out (clk_out[g]),
      .pending (pending[g])
    );
  end

endmodule

// File: tb/tb_multi_clock_gen.sv
// Bench for multi_clock_gen: vector table, directed corner sequences and a randomized
// run against an absolute-time scheduling model of each channel.
module tb_multi_clock_gen;

  localparam int N_CH    = 3;
  localparam int CNT_W   = 28;
  localparam int DEF_DIV = 20;
  localparam int CH_W    = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [N_CH-1:0]   ch_en = '0;
  logic              sync = 1'b0;
  logic              wr_en = 1'b0;
  logic [CH_W-1:0]   wr_ch = '0;
  logic [CNT_W-1:0]  wr_data = '0;
  logic              wr_err;
  logic [N_CH-1:0]   pending, tick, clk_out;

  always #5 clk = ~clk;

  multi_clock_gen #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ch_en   (ch_en),
    .sync    (sync),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_data (wr_data),
    .wr_err  (wr_err),
    .pending (pending),
    .tick    (tick),
    .clk_out (clk_out)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: each channel keeps the absolute edge number of its next tick.
  int cyc = 0;
  int k_act [N_CH];
  int k_sh  [N_CH];
  int nxt   [N_CH];
  bit pend  [N_CH];
  bit half  [N_CH];
  bit tk    [N_CH];
  bit m_err;

  function automatic logic [N_CH-1:0] pack(input bit a [N_CH]);
    logic [N_CH-1:0] r;
    for (int c = 0; c < N_CH; c++) r[c] = a[c];
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      k_act[c] = DEF_DIV;
      k_sh[c]  = DEF_DIV;
      pend[c]  = 1'b0;
      half[c]  = 1'b0;
      tk[c]    = 1'b0;
      nxt[c]   = cyc + DEF_DIV;
    end
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    int e;
    int kin;
    bit ld;
    e   = cyc + 1;
    kin = (wr_data == '0) ? 1 : int'(wr_data);
    for (int c = 0; c < N_CH; c++) begin
      ld = wr_en && (int'(wr_ch) == c);
      if (sync) begin
        if (ld) k_sh[c] = kin;
        k_act[c] = k_sh[c];
        pend[c]  = 1'b0;
        tk[c]    = 1'b0;
        half[c]  = 1'b0;
        nxt[c]   = e + k_act[c];
      end else if (!ch_en[c]) begin
        if (pend[c]) begin
          k_act[c] = k_sh[c];
          pend[c]  = 1'b0;
        end
        if (ld) begin
          k_sh[c] = kin;
          pend[c] = 1'b1;
        end
        tk[c]   = 1'b0;
        half[c] = 1'b0;
        nxt[c]  = e + k_act[c];
      end else begin
        tk[c] = (e == nxt[c]);
        if (tk[c]) begin
          half[c] = ~half[c];
          if (pend[c]) begin
            k_act[c] = k_sh[c];
            pend[c]  = 1'b0;
          end
          nxt[c] = e + k_act[c];
        end
        if (ld) begin
          k_sh[c] = kin;
          pend[c] = 1'b1;
        end
      end
    end
    m_err = wr_en && (int'(wr_ch) >= N_CH);
    cyc = e;
  endtask

  task automatic compare_model();
    check("model_tick",    32'(tick),    32'(pack(tk)));
    check("model_clk_out", 32'(clk_out), 32'(pack(half)));
    check("model_pending", 32'(pending), 32'(pack(pend)));
    check("model_wr_err",  32'(wr_err),  32'(m_err));
  endtask

  task automatic step();
    if (reset_n) model_edge();
    else begin
      cyc++;
      model_reset();
    end
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic drive(input logic [N_CH-1:0] en, input logic sy, input logic we,
                       input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] d);
    ch_en = en; sync = sy; wr_en = we; wr_ch = ch; wr_data = d;
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_tick",    32'(tick),    32'(0));
    check("async_rst_clk_out", 32'(clk_out), 32'(0));
    check("async_rst_pending", 32'(pending), 32'(0));
    check("async_rst_wr_err",  32'(wr_err),  32'(0));
    drive('0, 1'b0, 1'b0, '0, '0);
    step();
    #2 reset_n = 1'b1;
  endtask

  typedef struct {
    logic [N_CH-1:0]  en;
    logic             sy;
    logic             we;
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] d;
    logic [N_CH-1:0]  e_tick;
    logic [N_CH-1:0]  e_clk;
    logic [N_CH-1:0]  e_pend;
    logic             e_err;
  } vec_t;

  vec_t vt [19];

  initial begin
    vt[0]  = '{3'b000, 1'b0, 1'b1, 3'd3, 28'd7, 3'b000, 3'b000, 3'b000, 1'b1};
    vt[1]  = '{3'b000, 1'b0, 1'b1, 3'd0, 28'd2, 3'b000, 3'b000, 3'b001, 1'b0};
    vt[2]  = '{3'b000, 1'b0, 1'b0, 3'd0, 28'd0, 3'b000, 3'b000, 3'b000, 1'b0};
    vt[3]  = '{3'b001, 1'b0, 1'b0, 3'd0, 28'd0, 3'b000, 3'b000, 3'b000, 1'b0};
    vt[4]  = '{3'b001, 1'b0, 1'b0, 3'd0, 28'd0, 3'b001, 3'b001, 3'b000, 1'b0};
    vt[5]  = '{3'b001, 1'b0, 1'b0, 3'd0, 28'd0, 3'b000, 3'b001, 3'b000, 1'b0};
    vt[6]  = '{3'b001, 1'b0, 1'b0, 3'd0, 28'd0, 3'b001, 3'b000, 3'b000, 1'b0};
    vt[7]  = '{3'b001, 1'b0, 1'b1, 3'd0, 28'd1, 3'b000, 3'b000, 3'b001, 1'b0};
    vt[8]  = '{3'b001, 1'b0, 1'b0, 3'd0, 28'd0, 3'b001, 3'b001, 3'b000, 1'b0};
    vt[9]  = '{3'b001, 1'b0, 1'b0, 3'd0, 28'd0, 3'b001, 3'b000, 3'b000, 1'b0};
    vt[10] = '{3'b000, 1'b0, 1'b0, 3'd0, 28'd0, 3'b000, 3'b000, 3'b000, 1'b0};
    vt[11] = '{3'b001, 1'b1, 1'b1, 3'd1, 28'd0, 3'b000, 3'b000, 3'b000, 1'b0};
    vt[12] = '{3'b011, 1'b0, 1'b0, 3'd0, 28'd0, 3'b011, 3'b011, 3'b000, 1'b0};
    vt[13] = '{3'b011, 1'b0, 1'b1, 3'd7, 28'd3, 3'b011, 3'b000, 3'b000, 1'b1};
    vt[14] = '{3'b011, 1'b0, 1'b1, 3'd0, 28'd3, 3'b011, 3'b011, 3'b001, 1'b0};
    vt[15] = '{3'b011, 1'b0, 1'b0, 3'd0, 28'd0, 3'b011, 3'b000, 3'b000, 1'b0};
    vt[16] = '{3'b011, 1'b0, 1'b0, 3'd0, 28'd0, 3'b010, 3'b010, 3'b000, 1'b0};
    vt[17] = '{3'b011, 1'b0, 1'b0, 3'd0, 28'd0, 3'b010, 3'b000, 3'b000, 1'b0};
    vt[18] = '{3'b011, 1'b0, 1'b0, 3'd0, 28'd0, 3'b011, 3'b011, 3'b000, 1'b0};

    // Power-up reset, then default divisor: first tick on edge DEF_DIV.
    model_reset();
    step();
    step();
    #2 reset_n = 1'b1;
    drive('1, 1'b0, 1'b0, '0, '0);
    for (int e = 1; e <= DEF_DIV; e++) begin
      step();
      if (e >= DEF_DIV - 1) check("t1_first_tick", 32'(tick), 32'((e == DEF_DIV) ? 3'b111 : 3'b000));
    end
    drive('1, 1'b0, 1'b1, 3'd0, 28'd5);
    step();
    drive('1, 1'b0, 1'b0, '0, '0);
    check("t1_pending_before_rst", 32'(pending), 32'(3'b001));
    async_reset();

    // K=5 on ch0.
    drive('0, 1'b0, 1'b1, 3'd0, 28'd5);
    step();
    drive('0, 1'b0, 1'b0, '0, '0);
    step();
    ch_en = 3'b001;
    for (int e = 1; e <= 15; e++) begin
      step();
      check("t2_tick0", 32'(tick[0]), 32'((e % 5) == 0));
      check("t2_clk0",  32'(clk_out[0]), 32'(((e / 5) % 2) == 1));
    end

    // Divisor change mid-period: old period completes first.
    ch_en = 3'b000;
    step();
    ch_en = 3'b001;
    step();
    drive(3'b001, 1'b0, 1'b1, 3'd0, 28'd3);
    step();
    drive(3'b001, 1'b0, 1'b0, '0, '0);
    check("t3_pending_set", 32'(pending[0]), 32'(1));
    for (int e = 3; e <= 11; e++) begin
      step();
      check("t3_tick0",    32'(tick[0]),    32'(e == 5 || e == 8 || e == 11));
      check("t3_pending0", 32'(pending[0]), 32'(e < 5));
    end

    // K=0 stored as 1: tick every cycle, f/2 square.
    drive(3'b000, 1'b0, 1'b1, 3'd1, 28'd0);
    step();
    drive(3'b000, 1'b0, 1'b0, '0, '0);
    step();
    ch_en = 3'b010;
    for (int e = 1; e <= 6; e++) begin
      step();
      check("t4_tick1", 32'(tick[1]),    32'(1));
      check("t4_clk1",  32'(clk_out[1]), 32'(e % 2));
    end

    // Sync with simultaneous write to ch2.
    drive(3'b000, 1'b0, 1'b1, 3'd0, 28'd4);
    step();
    drive(3'b000, 1'b0, 1'b1, 3'd1, 28'd6);
    step();
    drive(3'b000, 1'b0, 1'b0, '0, '0);
    step();
    ch_en = 3'b001;
    step();
    step();
    ch_en = 3'b011;
    for (int i = 0; i < 3; i++) step();
    drive(3'b111, 1'b1, 1'b1, 3'd2, 28'd2);
    step();
    drive(3'b111, 1'b0, 1'b0, '0, '0);
    check("t5_sync_clk", 32'(clk_out), 32'(0));
    check("t5_sync_tick", 32'(tick), 32'(0));
    for (int e = 1; e <= 6; e++) begin
      step();
      check("t5_tick0", 32'(tick[0]), 32'(e == 4));
      check("t5_tick1", 32'(tick[1]), 32'(e == 6));
      check("t5_tick2", 32'(tick[2]), 32'((e % 2) == 0));
    end

    // Out-of-range write, then enable drop mid-period.
    drive(3'b111, 1'b0, 1'b1, 3'd3, 28'd7);
    step();
    drive(3'b111, 1'b0, 1'b0, '0, '0);
    check("t6_wr_err", 32'(wr_err), 32'(1));
    check("t6_pending", 32'(pending), 32'(0));
    step();
    check("t6_wr_err_clear", 32'(wr_err), 32'(0));
    sync = 1'b1;
    step();
    sync = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("t6_clk0_high", 32'(clk_out[0]), 32'(1));
    ch_en = 3'b110;
    step();
    check("t6_drop_clk0", 32'(clk_out[0]), 32'(0));
    check("t6_drop_tick0", 32'(tick[0]), 32'(0));
    ch_en = 3'b111;
    for (int e = 1; e <= 4; e++) begin
      step();
      check("t6_reen_tick0", 32'(tick[0]), 32'(e == 4));
    end

    // Vector table from a fresh reset.
    async_reset();
    foreach (vt[i]) begin
      drive(vt[i].en, vt[i].sy, vt[i].we, vt[i].ch, vt[i].d);
      step();
      check("vec_tick",    32'(tick),    32'(vt[i].e_tick));
      check("vec_clk_out", 32'(clk_out), 32'(vt[i].e_clk));
      check("vec_pending", 32'(pending), 32'(vt[i].e_pend));
      check("vec_wr_err",  32'(wr_err),  32'(vt[i].e_err));
    end

    // Randomized traffic against the model.
    drive('1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) ch_en = N_CH'($urandom_range(0, 7));
      sync    = ($urandom_range(0, 19) == 0);
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_ch   = CH_W'($urandom_range(0, 4));
      wr_data = CNT_W'($urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
